regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised integer register file for the RISC-V core, successor to the fixed 32x32 register file.
- Adds configurable width and depth, optional same-cycle write-to-read bypass, and a per-register pending-write scoreboard for multi-cycle units (load, mul/div).
- Adds a sequential clear engine so storage can sit in BRAM-style arrays without a single-cycle global reset.
- Sits between decode (read ports, scoreboard set) and writeback (write port).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; legal range 2..32; entry 0 is hardwired zero.
- AW, 5, address width; must satisfy 2**AW >= NREGS.
- BYPASS, 1, 1 = write data forwarded to read ports in the same cycle; 0 = reads return stored value only.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- ra1  in  AW  read address 1
- ra2  in  AW  read address 2
- rd1  out  XLEN  read data 1
- rd2  out  XLEN  read data 2
- rd1_busy  out  1  ra1 has a pending write
- rd2_busy  out  1  ra2 has a pending write
- wa  in  AW  write address
- wd  in  XLEN  write data
- wen  in  1  write enable
- sb_set  in  1  mark sb_addr pending (issue of a long-latency op)
- sb_addr  in  AW  register to mark pending
- clr_start  in  1  request full clear
- clr_busy  out  1  clear sequence in progress

Behaviour:
- Reset: reset, synchronous, active-low, reset_n; clock, clk. All state is sampled on posedge clk.
- Reset values: all scoreboard bits 0; FSM enters CLEAR with index 1; clr_busy = 1. While clr_busy, rd1, rd2, rd1_busy and rd2_busy are all 0.
- FSM states:
  - IDLE -> CLEAR when clr_start = 1.
  - CLEAR: writes 0 to entry idx and increments idx each cycle. At idx = NREGS-1, writes that entry, then goes to IDLE next cycle.
  - Total clear time is NREGS-1 cycles after reset release (or after the clr_start cycle).
- clr_start is ignored while in CLEAR. Reset asserted mid-clear restarts CLEAR at idx 1.
- During CLEAR: wen and sb_set are ignored; all scoreboard bits are held at 0.
- Reads (combinational, IDLE only):
  - rdN = 0 if raN == 0 or raN >= NREGS.
  - Else if BYPASS and wen and wa == raN, rdN = wd.
  - Else rdN = stored entry.
- Writes (IDLE only): on posedge, if wen and wa != 0 and wa < NREGS, the entry takes wd. Entry 0 is never written.
- Scoreboard:
  - On posedge, a write to wa clears sb[wa].
  - sb_set with a legal sb_addr != 0 sets sb[sb_addr].
  - If wen, wa == sb_addr and sb_set occur in the same cycle, set wins: the bit ends at 1 and the data is still written.
  - sb_set to 0 or to an out-of-range address is ignored.
- Busy outputs:
  - rdN_busy = sb[raN], except it is forced 0 when raN == 0, raN is out of range, or (BYPASS and wen and wa == raN).
  - With BYPASS = 0, a same-cycle write does not mask busy; busy drops the cycle after the write.
- Read latency: 0 cycles. Write-to-read latency: 0 cycles with BYPASS = 1, 1 cycle with BYPASS = 0.

Test Plan:
- Reset (default params): hold reset_n = 0 for 2 cycles, release -> clr_busy = 1 for exactly 31 cycles, then 0; every register reads 0.
- Write/read: write wa = 5, wd = 0xDEADBEEF; next cycle ra1 = 5 -> rd1 = 0xDEADBEEF. Write wa = 0, wd = 0x1234 -> ra2 = 0 reads 0.
- Bypass: BYPASS = 1, same cycle wen, wa = 7, wd = 0xA5A5A5A5, ra1 = 7 -> rd1 = 0xA5A5A5A5 in that cycle. Repeat with BYPASS = 0 -> rd1 = old value in that cycle, 0xA5A5A5A5 the next cycle.
- Scoreboard:
  - sb_set, sb_addr = 9 -> ra1 = 9 shows rd1_busy = 1 from the next cycle.
  - Write wa = 9 -> rd1_busy = 0 in the same cycle (BYPASS = 1).
  - Simultaneous sb_set = 9 and wen wa = 9 -> rd1_busy stays 1 and the data updates.
- Clear mid-operation: fill r1..r31 with distinct values, pulse clr_start -> writes ignored during CLEAR; after 31 cycles all registers read 0. Assert reset_n = 0 at clear idx 10 -> sequence restarts, and clr_busy stays high for 31 cycles after release.
- NREGS = 16, AW = 5: write wa = 20 ignored; ra1 = 20 -> rd1 = 0, rd1_busy = 0; clear takes 15 cycles.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised integer register file with optional write-to-read bypass,
// a pending-write scoreboard and a sequential clear engine.
module regfile_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AW     = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            rd1_busy,
    output logic            rd2_busy,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            wen,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    input  logic            clr_start,
    output logic            clr_busy
);

    localparam int unsigned IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e            state_q;
    logic [IW-1:0]     idx_q;
    logic              clr_busy_q;
    logic [NREGS-1:0]  sb_q, sb_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic              mem_we;
    logic [IW-1:0]     mem_wa;
    logic [XLEN-1:0]   mem_wd;

    logic              idle;
    logic              wr_ok;
    logic              set_ok;
    logic              ok1, ok2;

    // Address 0 and anything at or beyond NREGS are not real registers.
    function automatic logic legal(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NREGS);
    endfunction

    assign idle     = (state_q == IDLE);
    assign wr_ok    = idle && wen && legal(wa);
    assign set_ok   = idle && sb_set && legal(sb_addr);
    assign ok1      = idle && legal(ra1);
    assign ok2      = idle && legal(ra2);
    assign clr_busy = clr_busy_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            idx_q      <= IW'(1);
            clr_busy_q <= 1'b1;
            sb_q       <= '0;
        end else begin
            sb_q <= sb_d;
            case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        state_q    <= CLEAR;
                        idx_q      <= IW'(1);
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx_q == IW'(NREGS - 1)) begin
                        state_q    <= IDLE;
                        clr_busy_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: begin
                    state_q    <= CLEAR;
                    idx_q      <= IW'(1);
                    clr_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Set is applied after the write-clear so a coincident issue wins.
    always_comb begin
        sb_d = sb_q;
        if (!idle) begin
            sb_d = '0;
        end else begin
            if (wr_ok)  sb_d[wa[IW-1:0]]      = 1'b0;
            if (set_ok) sb_d[sb_addr[IW-1:0]] = 1'b1;
        end
    end

    // Single write port shared by the clear engine and writeback; no reset on storage.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa[IW-1:0];
        mem_wd = wd;
        if (reset_n) begin
            if (!idle) begin
                mem_we = 1'b1;
                mem_wa = idx_q;
                mem_wd = '0;
            end else begin
                mem_we = wr_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    always_comb begin
        rd1      = '0;
        rd1_busy = 1'b0;
        if (ok1) begin
            if (BYPASS && wen && (wa == ra1)) begin
                rd1 = wd;
            end else begin
                rd1      = mem_q[ra1[IW-1:0]];
                rd1_busy = sb_q[ra1[IW-1:0]];
            end
        end
    end

    always_comb begin
        rd2      = '0;
        rd2_busy = 1'b0;
        if (ok2) begin
            if (BYPASS && wen && (wa == ra2)) begin
                rd2 = wd;
            end else begin
                rd2      = mem_q[ra2[IW-1:0]];
                rd2_busy = sb_q[ra2[IW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default, no-bypass and 16-entry variants
// share one stimulus stream and are checked against hand-computed values.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  ra1, ra2, wa, sb_addr;
    logic [31:0] wd;
    logic        wen, sb_set, clr_start;

    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
    logic        a_b1, a_b2, b_b1, b_b2, c_b1, c_b2;
    logic        a_cb, b_cb, c_cb;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1'b1)) u_a (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2),
        .rd1(a_rd1), .rd2(a_rd2), .rd1_busy(a_b1), .rd2_busy(a_b2),
        .wa(wa), .wd(wd), .wen(wen), .sb_set(sb_set), .sb_addr(sb_addr),
        .clr_start(clr_start), .clr_busy(a_cb));

    regfile_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1'b0)) u_b (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2),
        .rd1(b_rd1), .rd2(b_rd2), .rd1_busy(b_b1), .rd2_busy(b_b2),
        .wa(wa), .wd(wd), .wen(wen), .sb_set(sb_set), .sb_addr(sb_addr),
        .clr_start(clr_start), .clr_busy(b_cb));

    regfile_sb #(.XLEN(32), .NREGS(16), .AW(5), .BYPASS(1'b1)) u_c (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2),
        .rd1(c_rd1), .rd2(c_rd2), .rd1_busy(c_b1), .rd2_busy(c_b2),
        .wa(wa), .wd(wd), .wen(wen), .sb_set(sb_set), .sb_addr(sb_addr),
        .clr_start(clr_start), .clr_busy(c_cb));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts cycles from now until each instance drops clr_busy (bounded).
    task automatic measure_clear(input string tag);
        int fa = -1, fb = -1, fc = -1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (fa < 0 && !a_cb) fa = c;
            if (fb < 0 && !b_cb) fb = c;
            if (fc < 0 && !c_cb) fc = c;
            if (c == 10) begin
                wen = 1'b0; sb_set = 1'b0;
            end
            tick();
        end
        checks++; if (fa !== 31) $display("FAIL %s_clear32 got %0d want 31", tag, fa); else passed++;
        checks++; if (fb !== 31) $display("FAIL %s_clear32nb got %0d want 31", tag, fb); else passed++;
        checks++; if (fc !== 15) $display("FAIL %s_clear16 got %0d want 15", tag, fc); else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        ra1 = 5'd3; ra2 = 5'd4;
        #1;
        checks++; if (a_cb !== 1'b1) $display("FAIL rst_clr_busy got %b want 1", a_cb); else passed++;
        checks++; if (a_rd1 !== 32'h0 || a_b1 !== 1'b0) $display("FAIL rst_rd1 got %h/%b want 0/0", a_rd1, a_b1); else passed++;
        reset_n = 1'b1;
        measure_clear("rst");
        for (int r = 0; r < 32; r++) begin
            ra1 = 5'(r); ra2 = 5'(31 - r);
            #1;
            checks++;
            if (a_rd1 !== 32'h0 || a_rd2 !== 32'h0 || a_b1 !== 1'b0)
                $display("FAIL rst_zero r%0d got %h %h %b want 0", r, a_rd1, a_rd2, a_b1);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        wen = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick();
        wen = 1'b0; ra1 = 5'd5;
        #1;
        checks++; if (a_rd1 !== 32'hDEADBEEF) $display("FAIL wr_r5 got %h want deadbeef", a_rd1); else passed++;
        checks++; if (b_rd1 !== 32'hDEADBEEF) $display("FAIL wr_r5_nb got %h want deadbeef", b_rd1); else passed++;
        wen = 1'b1; wa = 5'd0; wd = 32'h1234;
        tick();
        wen = 1'b0; ra2 = 5'd0;
        #1;
        checks++; if (a_rd2 !== 32'h0) $display("FAIL wr_r0 got %h want 0", a_rd2); else passed++;
    endtask

    task automatic test_bypass();
        wen = 1'b1; wa = 5'd7; wd = 32'h11111111;
        tick();
        wd = 32'hA5A5A5A5; ra1 = 5'd7;
        #1;
        checks++; if (a_rd1 !== 32'hA5A5A5A5) $display("FAIL byp_same got %h want a5a5a5a5", a_rd1); else passed++;
        checks++; if (b_rd1 !== 32'h11111111) $display("FAIL nobyp_same got %h want 11111111", b_rd1); else passed++;
        tick();
        wen = 1'b0;
        #1;
        checks++; if (b_rd1 !== 32'hA5A5A5A5) $display("FAIL nobyp_next got %h want a5a5a5a5", b_rd1); else passed++;
        checks++; if (a_rd1 !== 32'hA5A5A5A5) $display("FAIL byp_next got %h want a5a5a5a5", a_rd1); else passed++;
    endtask

    task automatic test_scoreboard();
        sb_set = 1'b1; sb_addr = 5'd9; ra1 = 5'd9;
        #1;
        checks++; if (a_b1 !== 1'b0) $display("FAIL sb_early got %b want 0", a_b1); else passed++;
        tick();
        sb_set = 1'b0;
        #1;
        checks++; if (a_b1 !== 1'b1 || b_b1 !== 1'b1) $display("FAIL sb_set got %b%b want 11", a_b1, b_b1); else passed++;
        wen = 1'b1; wa = 5'd9; wd = 32'h99;
        #1;
        checks++; if (a_b1 !== 1'b0) $display("FAIL sb_wr_mask got %b want 0", a_b1); else passed++;
        checks++; if (b_b1 !== 1'b1) $display("FAIL sb_wr_nomask got %b want 1", b_b1); else passed++;
        tick();
        wen = 1'b0;
        #1;
        checks++; if (a_b1 !== 1'b0 || b_b1 !== 1'b0) $display("FAIL sb_cleared got %b%b want 00", a_b1, b_b1); else passed++;
        checks++; if (a_rd1 !== 32'h99) $display("FAIL sb_wr_data got %h want 99", a_rd1); else passed++;
        wen = 1'b1; wa = 5'd9; wd = 32'h77; sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        wen = 1'b0; sb_set = 1'b0;
        #1;
        checks++; if (a_b1 !== 1'b1) $display("FAIL sb_setwins got %b want 1", a_b1); else passed++;
        checks++; if (a_rd1 !== 32'h77) $display("FAIL sb_setwins_data got %h want 77", a_rd1); else passed++;
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        sb_set = 1'b0; ra2 = 5'd9;
        #1;
        checks++; if (a_b2 !== 1'b1) $display("FAIL sb_port2 got %b want 1", a_b2); else passed++;
    endtask

    task automatic test_clear();
        for (int r = 1; r < 32; r++) begin
            wen = 1'b1; wa = 5'(r); wd = 32'h10000000 + 32'(r);
            tick();
        end
        wen = 1'b0; sb_set = 1'b1; sb_addr = 5'd3;
        tick();
        sb_set = 1'b0; ra1 = 5'd31; ra2 = 5'd3;
        #1;
        checks++; if (a_rd1 !== 32'h1000001F) $display("FAIL fill_r31 got %h want 1000001f", a_rd1); else passed++;
        checks++; if (a_b2 !== 1'b1) $display("FAIL fill_sb3 got %b want 1", a_b2); else passed++;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        wen = 1'b1; wa = 5'd4; wd = 32'hFFFF; sb_set = 1'b1; sb_addr = 5'd6;
        ra1 = 5'd4;
        #1;
        checks++; if (a_rd1 !== 32'h0 || a_b1 !== 1'b0) $display("FAIL clr_read got %h/%b want 0/0", a_rd1, a_b1); else passed++;
        measure_clear("clr");
        for (int r = 0; r < 32; r++) begin
            ra1 = 5'(r); ra2 = 5'(r);
            #1;
            checks++;
            if (a_rd1 !== 32'h0 || b_rd2 !== 32'h0 || a_b1 !== 1'b0 || (r < 16 && c_rd1 !== 32'h0))
                $display("FAIL clr_zero r%0d got %h %h %b %h want 0", r, a_rd1, b_rd2, a_b1, c_rd1);
            else passed++;
        end
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        measure_clear("midrst");
    endtask

    task automatic test_range();
        wen = 1'b1; wa = 5'd20; wd = 32'h00000BAD; ra1 = 5'd20;
        #1;
        checks++; if (c_rd1 !== 32'h0 || c_b1 !== 1'b0) $display("FAIL rng_byp got %h/%b want 0/0", c_rd1, c_b1); else passed++;
        tick();
        wen = 1'b0; sb_set = 1'b1; sb_addr = 5'd20;
        tick();
        sb_set = 1'b0;
        #1;
        checks++; if (c_rd1 !== 32'h0 || c_b1 !== 1'b0) $display("FAIL rng_r20 got %h/%b want 0/0", c_rd1, c_b1); else passed++;
        checks++; if (a_rd1 !== 32'hBAD || a_b1 !== 1'b1) $display("FAIL rng_r20_32 got %h/%b want bad/1", a_rd1, a_b1); else passed++;
        ra1 = 5'd4;
        #1;
        checks++; if (c_rd1 !== 32'h0 || c_b1 !== 1'b0) $display("FAIL rng_alias got %h/%b want 0/0", c_rd1, c_b1); else passed++;
    endtask

    initial begin
        reset_n = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0;
        wen = 1'b0; sb_set = 1'b0; sb_addr = '0; clr_start = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_clear();
        test_range();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
